dec_serial: RTL and testbench

Byte-serial sign-magnitude subtractor for MIX words. Computes in1 − in2 on 31-bit operands: bit 30 is the sign (1 = negative) and bits 29:0 are the magnitude, five 6-bit bytes. It is the subtracting counterpart of the combinational sign-magnitude adder. It trades area for latency by processing one byte per clock with a start/done handshake. It serves DEC/SUB-class instructions in the sequencer, where a multi-cycle execute slot is available.

---
 rtl/dec_serial.sv | 99 +++++++++
 tb/tb_dec_serial.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dec_serial.sv
// Byte-serial sign-magnitude subtractor (in1 - in2): result 6 clocks after an accepted start, one op per 7 clocks.
// No backpressure: start is taken only in IDLE, and a start seen while busy is dropped.
module dec_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [30:0] in1,
  input  logic [30:0] in2,
  output logic        busy,
  output logic        done,
  output logic [30:0] out,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [29:0] ra, rb;
  logic [29:0] acc_s, acc_d1, acc_d2;
  logic        sa, sb;
  logic        cy, bw1, bw2;
  logic [6:0]  s7, d17, d27;

  // Bit 6 of each 7-bit result is the carry (sum) or borrow (differences) into the next byte.
  always_comb begin
    s7  = {1'b0, ra[5:0]} + {1'b0, rb[5:0]} + {6'd0, cy};
    d17 = {1'b0, ra[5:0]} - {1'b0, rb[5:0]} - {6'd0, bw1};
    d27 = {1'b0, rb[5:0]} - {1'b0, ra[5:0]} - {6'd0, bw2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ra       <= 30'd0;
      rb       <= 30'd0;
      acc_s    <= 30'd0;
      acc_d1   <= 30'd0;
      acc_d2   <= 30'd0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      cy       <= 1'b0;
      bw1      <= 1'b0;
      bw2      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= 31'd0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= in1[29:0];
            rb    <= in2[29:0];
            sa    <= in1[30];
            sb    <= ~in2[30];
            cy    <= 1'b0;
            bw1   <= 1'b0;
            bw2   <= 1'b0;
            cnt   <= 3'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ra     <= {6'd0, ra[29:6]};
          rb     <= {6'd0, rb[29:6]};
          acc_s  <= {s7[5:0],  acc_s[29:6]};
          acc_d1 <= {d17[5:0], acc_d1[29:6]};
          acc_d2 <= {d27[5:0], acc_d2[29:6]};
          cy     <= s7[6];
          bw1    <= d17[6];
          bw2    <= d27[6];
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd4) state <= FINISH;
        end
        FINISH: begin
          if (sa == sb) begin
            out      <= {sa, acc_s};
            overflow <= cy;
          end else if (!bw1) begin
            out      <= {sa, acc_d1};
            overflow <= 1'b0;
          end else begin
            out      <= {sb, acc_d2};
            overflow <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_serial.sv
// Directed bench for dec_serial; expectations queued at acceptance, checked by a done monitor.
module tb_dec_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [30:0] in1, in2;
  logic        busy, done, overflow;
  logic [30:0] out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ndone = 0;
  int npush = 0;

  logic [30:0] q_out[$];
  logic        q_ov[$];
  int          q_cyc[$];

  dec_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      ndone++;
      if (q_out.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done (out=%h)", out);
      end else begin
        logic [30:0] eo;
        logic        ev;
        int          ec;
        eo = q_out.pop_front();
        ev = q_ov.pop_front();
        ec = q_cyc.pop_front();
        chk("out", {1'b0, out}, {1'b0, eo});
        chk("overflow", {31'd0, overflow}, {31'd0, ev});
        chk("latency", cyc - ec, 32'd6);
      end
    end
  end

  // Caller must be at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [30:0] a, input logic [30:0] b, input logic [30:0] eo,
                       input logic eov, input bit push, input bit hold);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      q_out.push_back(eo);
      q_ov.push_back(eov);
      q_cyc.push_back(cyc);
      npush++;
    end
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (!hold) start = 1'b0;
    in1 = 31'h7FFFFFFF;
    in2 = 31'h2AAAAAAA;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL done_timeout: got no done expected done within 20 cycles");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in1   = 31'd0;
    in2   = 31'd0;
    idle(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", {1'b0, out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    issue(31'd5, 31'd3, 31'h00000002, 1'b0, 1, 0);                  wait_done(); idle(2);
    issue(31'd3, 31'd5, 31'h40000002, 1'b0, 1, 0);                  wait_done(); idle(2);
    issue(31'd7, 31'd7, 31'h00000000, 1'b0, 1, 0);                  wait_done(); idle(2);
    issue(31'h40000007, 31'h40000007, 31'h40000000, 1'b0, 1, 0);    wait_done(); idle(2);
    issue(31'h3FFFFFFF, 31'h40000001, 31'h00000000, 1'b1, 1, 0);    wait_done(); idle(2);
    issue(31'h00001000, 31'd1, 31'h00000FFF, 1'b0, 1, 0);           wait_done(); idle(2);
    issue(31'd63, 31'h40000001, 31'h00000040, 1'b0, 1, 0);          wait_done(); idle(2);

    // start held high through the whole operation: one result only
    issue(31'd100, 31'd40, 31'd60, 1'b0, 1, 1);
    wait_done();
    start = 1'b0;
    idle(3);
    chk("held_start_busy", {31'd0, busy}, 32'd0);

    // back-to-back: second start issued in the done cycle
    issue(31'd10, 31'd4, 31'd6, 1'b0, 1, 0);
    wait_done();
    issue(31'h40000010, 31'd16, 31'h40000020, 1'b0, 1, 0);
    wait_done();
    idle(2);

    // reset after E3 of a run: everything clears, no done follows
    issue(31'h00012345, 31'd1, 31'd0, 1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_out", {1'b0, out}, 32'd0);
    chk("midrun_rst_ovf", {31'd0, overflow}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(10);

    issue(31'd20, 31'd30, 31'h4000000A, 1'b0, 1, 0);
    wait_done();
    idle(3);

    chk("queue_empty", q_out.size(), 32'd0);
    chk("done_count", ndone, npush);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
